// File: rtl/c_tile_drain_stream.sv
// Drains an M x N result tile from the C-tile SRAM controller over a single-outstanding
// read port into a FWFT FIFO. Define C_DRAIN_COL_MAJOR_EN for column-major traversal.
module c_tile_drain_stream #(
    parameter int unsigned M          = 8,
    parameter int unsigned N          = 8,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ROW_W      = (M <= 1) ? 1 : $clog2(M),
    parameter int unsigned COL_W      = (N <= 1) ? 1 : $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    input  logic              c_valid_i,
    output logic              rd_en,
    output logic              rd_re,
    output logic [ROW_W-1:0]  rd_row,
    output logic [COL_W-1:0]  rd_col,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              rd_rvalid,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [ROW_W-1:0]  m_row,
    output logic [COL_W-1:0]  m_col,
    output logic              m_last,
    output logic              busy,
    output logic              done
);

    localparam int unsigned PTR_W = (FIFO_DEPTH <= 1) ? 1 : $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned ENT_W = DATA_W + ROW_W + COL_W + 1;

    typedef enum logic [2:0] {StIdle, StWaitCv, StReq, StWaitRd, StFlush} state_e;

    state_e           state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d, row_nxt;
    logic [COL_W-1:0] col_q, col_d, col_nxt;

    logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             push, pop, empty, space, is_last;
    logic [ENT_W-1:0] head;

    assign is_last = (row_q == ROW_W'(M - 1)) && (col_q == COL_W'(N - 1));
    assign empty   = (cnt_q == '0);
    assign space   = (cnt_q < CNT_W'(FIFO_DEPTH));
    assign pop     = !empty && m_ready;

    always_comb begin
        row_nxt = row_q;
        col_nxt = col_q;
`ifdef C_DRAIN_COL_MAJOR_EN
        if (row_q == ROW_W'(M - 1)) begin
            row_nxt = '0;
            col_nxt = (col_q == COL_W'(N - 1)) ? '0 : col_q + COL_W'(1);
        end else begin
            row_nxt = row_q + ROW_W'(1);
        end
`else
        if (col_q == COL_W'(N - 1)) begin
            col_nxt = '0;
            row_nxt = (row_q == ROW_W'(M - 1)) ? '0 : row_q + ROW_W'(1);
        end else begin
            col_nxt = col_q + COL_W'(1);
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        rd_en   = 1'b0;
        rd_re   = 1'b0;
        push    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (go) begin
                    state_d = StWaitCv;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            StWaitCv: begin
                if (c_valid_i) state_d = StReq;
            end
            // A free slot is reserved before issuing, so the return can always be pushed.
            StReq: begin
                if (space) begin
                    rd_en   = 1'b1;
                    rd_re   = 1'b1;
                    state_d = StWaitRd;
                end
            end
            StWaitRd: begin
                if (rd_rvalid) begin
                    push    = 1'b1;
                    row_d   = row_nxt;
                    col_d   = col_nxt;
                    state_d = is_last ? StFlush : StReq;
                end
            end
            StFlush: begin
                if (pop && cnt_q == CNT_W'(1)) begin
                    done    = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            row_q    <= '0;
            col_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push && !pop)      cnt_q <= cnt_q + CNT_W'(1);
            else if (pop && !push) cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {rd_data, row_q, col_q, is_last};
    end

    assign head    = mem_q[rd_ptr_q];
    assign m_valid = !empty;
    assign {m_data, m_row, m_col, m_last} = m_valid ? head : '0;
    assign rd_row  = row_q;
    assign rd_col  = col_q;
    assign busy    = (state_q != StIdle);

endmodule

// File: tb/tb_c_tile_drain_stream.sv
// Self-checking bench for c_tile_drain_stream: table of drain scenarios plus
// hand-written back-pressure and reset-abort sequences against a controller model.
module tb_c_tile_drain_stream;

    localparam int M  = 8;
    localparam int N  = 8;
    localparam int DW = 32;
    localparam int FD = 4;
    localparam int RW = 3;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst, go, c_valid_i, m_ready;
    logic          rd_en, rd_re, rd_rvalid, m_valid, m_last, busy, done;
    logic [RW-1:0] rd_row, m_row;
    logic [CW-1:0] rd_col, m_col;
    logic [DW-1:0] rd_data, m_data;

    always #5 clk = ~clk;

    c_tile_drain_stream #(.M(M), .N(N), .DATA_W(DW), .FIFO_DEPTH(FD)) dut (
        .clk       (clk),
        .rst       (rst),
        .go        (go),
        .c_valid_i (c_valid_i),
        .rd_en     (rd_en),
        .rd_re     (rd_re),
        .rd_row    (rd_row),
        .rd_col    (rd_col),
        .rd_data   (rd_data),
        .rd_rvalid (rd_rvalid),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_row     (m_row),
        .m_col     (m_col),
        .m_last    (m_last),
        .busy      (busy),
        .done      (done)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Controller model: returns row*16+col, lat cycles after the request cycle.
    int            lat = 2;
    int            lat_cnt = 0;
    int            req_cnt = 0;
    bit            pend = 0;
    logic [RW-1:0] prow = '0;
    logic [CW-1:0] pcol = '0;
    logic          ctrl_rv = 1'b0;
    logic [DW-1:0] ctrl_data = '0;
    logic          spur = 1'b0;

    assign rd_rvalid = ctrl_rv | spur;
    assign rd_data   = spur ? 32'hDEAD_BEEF : ctrl_data;

    always @(negedge clk) begin
        if (pend && lat_cnt == 1) begin
            ctrl_rv   = 1'b1;
            ctrl_data = DW'(prow) * 16 + DW'(pcol);
            pend      = 1'b0;
        end else begin
            ctrl_rv = 1'b0;
            if (pend) lat_cnt = lat_cnt - 1;
        end
        if (rd_en && rd_re) begin
            chk("single_outstanding", 64'(pend), 64'd0);
            req_cnt++;
            pend    = 1'b1;
            lat_cnt = lat;
            prow    = rd_row;
            pcol    = rd_col;
        end
    end

    function automatic void exp_word(input int k, output int r, output int c);
`ifdef C_DRAIN_COL_MAJOR_EN
        r = k % M;
        c = k / M;
`else
        r = k / N;
        c = k % N;
`endif
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rd_en"},   64'(rd_en),   64'd0);
        chk({tag, "_rd_re"},   64'(rd_re),   64'd0);
        chk({tag, "_rd_row"},  64'(rd_row),  64'd0);
        chk({tag, "_rd_col"},  64'(rd_col),  64'd0);
        chk({tag, "_m_valid"}, 64'(m_valid), 64'd0);
        chk({tag, "_m_last"},  64'(m_last),  64'd0);
        chk({tag, "_m_data"},  64'(m_data),  64'd0);
        chk({tag, "_m_row"},   64'(m_row),   64'd0);
        chk({tag, "_m_col"},   64'(m_col),   64'd0);
        chk({tag, "_busy"},    64'(busy),    64'd0);
        chk({tag, "_done"},    64'(done),    64'd0);
    endtask

    // Pulse go, optionally hold c_valid_i low, then expect the first request.
    task automatic start_go(input int cv_delay);
        int seen;
        seen = 0;
        @(negedge clk);
        go        = 1'b1;
        c_valid_i = (cv_delay == 0);
        @(negedge clk);
        go = 1'b0;
        #1;
        chk("busy_after_go", 64'(busy), 64'd1);
        if (cv_delay > 0) begin
            repeat (cv_delay) begin
                @(negedge clk);
                #1;
                if (rd_en) seen++;
            end
            chk("no_rd_en_in_wait_cv", 64'(seen), 64'd0);
            c_valid_i = 1'b1;
        end
        @(negedge clk);
        #1;
        chk("first_req", 64'(rd_en), 64'd1);
    endtask

    // Accept stop_at words, checking order, tags, data, last, done and stall stability.
    task automatic stream(input int rdy_pct, input int stop_at, output int got);
        int            cyc, r, c;
        bit            stalled;
        logic [DW-1:0] sd;
        logic [RW-1:0] sr;
        logic [CW-1:0] sc;
        logic          sl;
        got = 0;
        cyc = 0;
        stalled = 0;
        sd = '0; sr = '0; sc = '0; sl = 1'b0;
        while (got < stop_at && cyc < 3000) begin
            @(negedge clk);
            m_ready = ($urandom_range(99) < rdy_pct);
            #1;
            cyc++;
            if (stalled) begin
                chk("stall_valid", 64'(m_valid), 64'd1);
                chk("stall_data",  64'(m_data),  64'(sd));
                chk("stall_row",   64'(m_row),   64'(sr));
                chk("stall_col",   64'(m_col),   64'(sc));
                chk("stall_last",  64'(m_last),  64'(sl));
            end
            if (m_valid && m_ready) begin
                exp_word(got, r, c);
                chk("word_row",  64'(m_row),  64'(r));
                chk("word_col",  64'(m_col),  64'(c));
                chk("word_data", 64'(m_data), 64'(r * 16 + c));
                chk("word_last", 64'(m_last), 64'(got == M * N - 1));
                chk("word_done", 64'(done),   64'(got == M * N - 1));
                got++;
                stalled = 0;
            end else begin
                chk("done_quiet", 64'(done), 64'd0);
                stalled = m_valid;
                sd = m_data; sr = m_row; sc = m_col; sl = m_last;
            end
        end
        if (got < stop_at) chk("stream_timeout", 64'(got), 64'(stop_at));
    endtask

    task automatic after_drain();
        @(negedge clk);
        #1;
        chk("busy_after_done", 64'(busy),    64'd0);
        chk("done_one_pulse",  64'(done),    64'd0);
        chk("fifo_empty_end",  64'(m_valid), 64'd0);
    endtask

    typedef struct {
        int cv_delay;
        int rdy_pct;
        int lat;
        int exp_words;
        int exp_reqs;
    } vec_t;

    initial begin
        vec_t vecs[5];
        int   got;

        vecs[0] = '{cv_delay: 0,  rdy_pct: 100, lat: 2, exp_words: 64, exp_reqs: 64};
        vecs[1] = '{cv_delay: 20, rdy_pct: 100, lat: 2, exp_words: 64, exp_reqs: 64};
        vecs[2] = '{cv_delay: 0,  rdy_pct: 50,  lat: 2, exp_words: 64, exp_reqs: 64};
        vecs[3] = '{cv_delay: 3,  rdy_pct: 100, lat: 1, exp_words: 64, exp_reqs: 64};
        vecs[4] = '{cv_delay: 0,  rdy_pct: 30,  lat: 4, exp_words: 64, exp_reqs: 64};

        rst = 1'b1; go = 1'b0; c_valid_i = 1'b0; m_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk_reset_outputs("reset");
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            lat       = vecs[i].lat;
            req_cnt   = 0;
            m_ready   = 1'b0;
            c_valid_i = 1'b0;
            start_go(vecs[i].cv_delay);
            stream(vecs[i].rdy_pct, M * N, got);
            chk("word_count", 64'(got), 64'(vecs[i].exp_words));
            chk("req_count",  64'(req_cnt), 64'(vecs[i].exp_reqs));
            after_drain();
        end

        // Downstream stalled: only FIFO_DEPTH reads may be issued.
        lat = 2; req_cnt = 0; m_ready = 1'b0; c_valid_i = 1'b0;
        start_go(0);
        repeat (60) @(negedge clk);
        #1;
        chk("blocked_reads",   64'(req_cnt), 64'(FD));
        chk("blocked_rd_en",   64'(rd_en),   64'd0);
        chk("blocked_m_valid", 64'(m_valid), 64'd1);
        stream(100, M * N, got);
        chk("blocked_words", 64'(got),     64'(M * N));
        chk("blocked_reqs",  64'(req_cnt), 64'(M * N));
        after_drain();

        // Spurious return while idle must not be pushed.
        @(negedge clk);
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        #1;
        chk("spurious_no_push", 64'(m_valid), 64'd0);
        chk("spurious_idle",    64'(busy),    64'd0);

        // Reset after element 10 with a read possibly in flight.
        req_cnt = 0; c_valid_i = 1'b0;
        start_go(0);
        stream(100, 10, got);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk_reset_outputs("abort");
        rst = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        chk("abort_no_push", 64'(m_valid), 64'd0);
        chk("abort_idle",    64'(busy),    64'd0);
        req_cnt = 0; c_valid_i = 1'b0; m_ready = 1'b0;
        start_go(0);
        stream(100, M * N, got);
        chk("redrain_words", 64'(got),     64'(M * N));
        chk("redrain_reqs",  64'(req_cnt), 64'(M * N));
        after_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
